alu_seq_param: RTL and testbench

ALU_SEQ_PARAM -- requirements
Module: alu_seq_param

---
 rtl/alu_seq_param.sv | 157 +++++++++++++++
 tb/tb_alu_seq_param.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_param.sv
// alu_seq_param: sequential ALU with a request/response handshake.
// Add and subtract finish in one cycle. Multiply (shift-add) and divide
// (restoring) take WIDTH iteration cycles. Divide by zero finishes at once
// with saturated results.
module alu_seq_param #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [1:0]           opcode,
  output logic [2*WIDTH-1:0]   result,
  output logic [WIDTH-1:0]     remainder,
  output logic                 carry_flag,
  output logic                 overflow_flag,
  output logic                 div_by_zero,
  output logic                 out_valid
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_nxt;
  logic [1:0]           op_q;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   prod;
  logic [2*WIDTH-1:0]   mul_sum;
  logic [WIDTH-1:0]     div_q;
  logic [WIDTH-1:0]     div_r;
  logic [WIDTH-1:0]     div_d;
  logic [WIDTH:0]       div_sh;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_q_nxt;
  logic [WIDTH-1:0]     div_r_nxt;
  logic                 accept;
  logic                 is_long;
  logic                 last;

  // {carry, overflow, zero-extended (WIDTH+1)-bit sum or difference}
  function automatic logic [2*WIDTH+1:0] add_sub(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic sub);
    logic [WIDTH:0] s;
    logic           ovf;
    if (sub) begin
      s   = {1'b0, a} - {1'b0, b};
      ovf = (a[WIDTH-1] != b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    end else begin
      s   = {1'b0, a} + {1'b0, b};
      ovf = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    end
    return {s[WIDTH], ovf, {(WIDTH-1){1'b0}}, s};
  endfunction

  // {carry, overflow} for a full-width unsigned product
  function automatic logic [1:0] mul_flags(input logic [2*WIDTH-1:0] p);
    return {|p[2*WIDTH-1:WIDTH], p[2*WIDTH-1:WIDTH] != {WIDTH{p[WIDTH-1]}}};
  endfunction

  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign is_long   = (opcode == OP_MUL) || ((opcode == 2'b11) && (B != '0));
  assign last      = (cnt == CW'(WIDTH - 1));

  // One iteration of shift-add multiply and restoring divide
  always_comb begin
    mul_sum   = prod + (mplier[0] ? mcand : '0);
    div_sh    = {div_r, div_q[WIDTH-1]};
    div_ge    = (div_sh >= {1'b0, div_d});
    div_r_nxt = div_ge ? WIDTH'(div_sh - {1'b0, div_d}) : div_sh[WIDTH-1:0];
    div_q_nxt = {div_q[WIDTH-2:0], div_ge};
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = is_long ? CALC : DONE;
      CALC:    if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Iteration registers: loaded on acceptance, stepped once per CALC cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= opcode;
      mcand  <= {{WIDTH{1'b0}}, A};
      mplier <= B;
      prod   <= '0;
      div_q  <= A;
      div_r  <= '0;
      div_d  <= B;
      cnt    <= '0;
    end else if (state == CALC) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      prod   <= mul_sum;
      div_q  <= div_q_nxt;
      div_r  <= div_r_nxt;
      cnt    <= cnt + 1'b1;
    end
  end

  // Output registers: written only on the edge that enters DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result        <= '0;
      remainder     <= '0;
      carry_flag    <= 1'b0;
      overflow_flag <= 1'b0;
      div_by_zero   <= 1'b0;
    end else if (accept && !is_long) begin
      if (opcode == OP_ADD || opcode == OP_SUB) begin
        {carry_flag, overflow_flag, result} <= add_sub(A, B, opcode[0]);
        remainder   <= '0;
        div_by_zero <= 1'b0;
      end else begin
        result        <= '1;
        remainder     <= '1;
        carry_flag    <= 1'b1;
        overflow_flag <= 1'b1;
        div_by_zero   <= 1'b1;
      end
    end else if (state == CALC && last) begin
      div_by_zero <= 1'b0;
      if (op_q == OP_MUL) begin
        result                      <= mul_sum;
        remainder                   <= '0;
        {carry_flag, overflow_flag} <= mul_flags(mul_sum);
      end else begin
        result        <= {{WIDTH{1'b0}}, div_q_nxt};
        remainder     <= div_r_nxt;
        carry_flag    <= 1'b0;
        overflow_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_param.sv
// Self-checking bench for alu_seq_param (WIDTH = 8): scoreboard queue fed by
// the stimulus, monitor compares on every out_valid and checks hold otherwise.
module tb_alu_seq_param;
  localparam int W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     A = '0;
  logic [W-1:0]     B = '0;
  logic [1:0]       opcode = 2'b00;
  logic [2*W-1:0]   result;
  logic [W-1:0]     remainder;
  logic             carry_flag, overflow_flag, div_by_zero, out_valid;

  alu_seq_param #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .opcode(opcode), .result(result), .remainder(remainder),
    .carry_flag(carry_flag), .overflow_flag(overflow_flag),
    .div_by_zero(div_by_zero), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint res;
    longint rem;
    bit     c;
    bit     o;
    bit     dz;
    int     lat;
    longint due;
  } exp_t;

  exp_t   sb[$];
  longint cyc = 0;
  int     checks = 0;
  int     fails = 0;
  logic [2*W+W+2:0] last_out;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc > 30000) begin
      $display("FAIL watchdog cycles=%0d limit=30000", cyc);
      $fatal(1, "watchdog");
    end
  end

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference model from the arithmetic definitions
  function automatic exp_t model(input longint a, input longint b, input int op);
    exp_t   e;
    longint sa, sb_, t;
    sa = (a >= 2**(W-1)) ? a - 2**W : a;
    sb_ = (b >= 2**(W-1)) ? b - 2**W : b;
    e.rem = 0; e.c = 0; e.o = 0; e.dz = 0; e.lat = 0; e.due = 0;
    case (op)
      0: begin
        e.res = a + b;
        e.c = (a + b) >= 2**W;
        t = sa + sb_;
        e.o = (t > 2**(W-1) - 1) || (t < -(2**(W-1)));
      end
      1: begin
        e.res = (a - b + 2**(W+1)) % 2**(W+1);
        e.c = a < b;
        t = sa - sb_;
        e.o = (t > 2**(W-1) - 1) || (t < -(2**(W-1)));
      end
      2: begin
        e.res = a * b;
        e.c = (a * b) >= 2**W;
        e.o = (a * b) >= 2**(W-1);
        e.lat = W;
      end
      default: begin
        if (b == 0) begin
          e.res = 2**(2*W) - 1; e.rem = 2**W - 1;
          e.c = 1; e.o = 1; e.dz = 1;
        end else begin
          e.res = a / b; e.rem = a % b; e.lat = W;
        end
      end
    endcase
    return e;
  endfunction

  function automatic exp_t mk(input longint res, input longint rem, input bit c,
                              input bit o, input bit dz, input int lat);
    exp_t e;
    e.res = res; e.rem = rem; e.c = c; e.o = o; e.dz = dz; e.lat = lat; e.due = 0;
    return e;
  endfunction

  // Issue one request; hold keeps in_valid high (with junk operands) for
  // that many extra edges after acceptance.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] op, input exp_t e, input int hold);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++; fails++;
      $display("FAIL in_ready_timeout got=0 expected=1");
      return;
    end
    A = a; B = b; opcode = op; in_valid = 1'b1;
    e.due = cyc + 1 + e.lat;
    sb.push_back(e);
    @(posedge clk); #1;
    A = W'($urandom); B = W'($urandom); opcode = 2'($urandom);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      A = W'($urandom); B = W'($urandom); opcode = 2'($urandom);
    end
    in_valid = 1'b0;
  endtask

  // Monitor: compare on out_valid, otherwise outputs must hold
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last_out = {result, remainder, carry_flag, overflow_flag, div_by_zero};
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_out_valid got=1 expected=0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("latency_cycle", cyc, e.due);
        check("result", longint'(result), e.res);
        check("remainder", longint'(remainder), e.rem);
        check("carry_flag", longint'(carry_flag), longint'(e.c));
        check("overflow_flag", longint'(overflow_flag), longint'(e.o));
        check("div_by_zero", longint'(div_by_zero), longint'(e.dz));
      end
      last_out = {result, remainder, carry_flag, overflow_flag, div_by_zero};
    end else begin
      check("hold_outputs",
            longint'({result, remainder, carry_flag, overflow_flag, div_by_zero}),
            longint'(last_out));
    end
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic [1:0]   rop;
    exp_t         e;
    int           guard;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", longint'(in_ready), 0);
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_result", longint'(result), 0);
    check("reset_flags", longint'({remainder, carry_flag, overflow_flag, div_by_zero}), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", longint'(in_ready), 1);

    // Directed vectors
    issue(8'd200, 8'd100, 2'b00, mk(16'h012C, 0, 1, 0, 0, 0), 0);
    issue(8'd100, 8'd100, 2'b00, mk(16'h00C8, 0, 0, 1, 0, 0), 0);
    issue(8'd5,   8'd9,   2'b01, mk(16'h01FC, 0, 1, 0, 0, 0), 0);
    issue(8'd15,  8'd17,  2'b10, mk(16'h00FF, 0, 0, 1, 0, W), 0);
    issue(8'd255, 8'd255, 2'b10, mk(16'hFE01, 0, 1, 1, 0, W), 0);
    issue(8'd200, 8'd7,   2'b11, mk(16'h001C, 4, 0, 0, 0, W), 0);
    issue(8'd200, 8'd0,   2'b11, mk(16'hFFFF, 8'hFF, 1, 1, 1, 0), 0);
    // in_valid held high through a whole multiply, operands scrambled
    issue(8'd15,  8'd17,  2'b10, mk(16'h00FF, 0, 0, 1, 0, W), W + 1);

    // Abandoned divide: reset sampled at the 4th edge after acceptance
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    A = 8'd200; B = 8'd7; opcode = 2'b11; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_in_ready_low", longint'(in_ready), 0);
    check("abort_out_valid", longint'(out_valid), 0);
    check("abort_outputs_zero",
          longint'({result, remainder, carry_flag, overflow_flag, div_by_zero}), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready_after", longint'(in_ready), 1);
    check("abort_no_out_valid", longint'(out_valid), 0);

    // Randomized operations against the reference model
    for (int n = 0; n < 200; n++) begin
      ra = W'($urandom); rb = W'($urandom); rop = 2'($urandom);
      if ($urandom_range(0, 7) == 0) rb = '0;
      if ($urandom_range(0, 15) == 0) begin ra = '1; rb = '1; end
      e = model(longint'(ra), longint'(rb), int'(rop));
      issue(ra, rb, rop, e, (rop == 2'b10 && $urandom_range(0, 3) == 0) ? W + 1 : 0);
    end

    // Drain
    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("scoreboard_drained", longint'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
